taxel_logic_aer_ctrl: RTL and testbench

//  Clocked, multi-channel successor to the per-taxel spike latch. Each channel

---
 rtl/taxel_logic_pkg.sv | 19 +
 rtl/taxel_ch_latch.sv | 48 ++++
 rtl/taxel_logic_aer_ctrl.sv | 137 +++++++++++++
 tb/tb_taxel_logic_aer_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/taxel_logic_pkg.sv
// Shared types and helpers for the multi-channel taxel AER controller.
package taxel_logic_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } aer_state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/taxel_ch_latch.sv
// One spike channel: synchroniser, rising-edge detect, gate/refractory qualify,
// pending latch and refractory down-counter.
module taxel_ch_latch #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned REFR_W      = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              x,
    input  logic              block,
    input  logic              clr,
    input  logic [REFR_W-1:0] refr_cycles,
    output logic              pending,
    output logic              drop_evt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_dly_q;
    logic                   pending_q;
    logic [REFR_W-1:0]      refr_q;
    logic                   evt;
    logic                   accept;

    assign evt      = sync_q[SYNC_STAGES-1] & ~s_dly_q;
    assign accept   = evt & ~block & (refr_q == '0);
    // A set coinciding with the grant clear keeps the latch set and is not an overrun.
    assign drop_evt = accept & pending_q & ~clr;
    assign pending  = pending_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q    <= '0;
            s_dly_q   <= 1'b0;
            pending_q <= 1'b0;
            refr_q    <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], x};
            s_dly_q   <= sync_q[SYNC_STAGES-1];
            pending_q <= accept | (pending_q & ~clr);
            if (clr) begin
                refr_q <= refr_cycles;
            end else if (refr_q != '0) begin
                refr_q <= refr_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/taxel_logic_aer_ctrl.sv
// Multi-channel taxel spike front end: per-channel latches, round-robin arbiter
// and a 4-phase req/ack handshake towards the AER encoder.
module taxel_logic_aer_ctrl
    import taxel_logic_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned REFR_W      = 4,
    parameter int unsigned DROP_W      = 8,
    localparam int unsigned CH_W       = clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              spkgate_x,
    input  logic              spkgate_y,
    input  logic              vmode,
    input  logic [N_CH-1:0]   spk_in,
    input  logic              spk_in_imode,
    input  logic [REFR_W-1:0] refr_cycles,
    output logic              req,
    input  logic              ack,
    output logic [CH_W-1:0]   ev_ch,
    output logic [N_CH-1:0]   pending,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    aer_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic [CH_W-1:0]   ev_ch_q, ev_ch_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DROP_W-1:0] drop_q;
    logic [N_CH-1:0]   x;
    logic [N_CH-1:0]   clr;
    logic [N_CH-1:0]   drop_evt;
    logic              ack_done;
    logic              grant_valid;
    logic [CH_W-1:0]   grant_ch;
    logic [CH_W-1:0]   idx;

    // In current mode only ch0 is live, fed from the imode input.
    always_comb begin
        x    = spk_in & {N_CH{vmode}};
        x[0] = vmode ? spk_in[0] : spk_in_imode;
    end

    always_comb begin
        for (int unsigned k = 0; k < N_CH; k++) begin
            clr[k] = ack_done && (ev_ch_q == CH_W'(k));
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        taxel_ch_latch #(
            .SYNC_STAGES(SYNC_STAGES),
            .REFR_W     (REFR_W)
        ) u_ch (
            .clk        (clk),
            .rstn       (rstn),
            .x          (x[k]),
            .block      (spkgate_x & spkgate_y),
            .clr        (clr[k]),
            .refr_cycles(refr_cycles),
            .pending    (pending[k]),
            .drop_evt   (drop_evt[k])
        );
    end

    // Search starts just after the last granted channel, wrapping.
    always_comb begin
        grant_valid = 1'b0;
        grant_ch    = '0;
        idx         = '0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            idx = CH_W'((32'(rr_ptr_q) + i) % N_CH);
            if (!grant_valid && pending[idx]) begin
                grant_valid = 1'b1;
                grant_ch    = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        ev_ch_d  = ev_ch_q;
        rr_ptr_d = rr_ptr_q;
        ack_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    ev_ch_d  = grant_ch;
                    rr_ptr_d = grant_ch;
                    req_d    = 1'b1;
                    state_d  = StReq;
                end
            end
            StReq: begin
                if (ack) begin
                    req_d    = 1'b0;
                    ack_done = 1'b1;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (!ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            req_q    <= 1'b0;
            ev_ch_q  <= '0;
            rr_ptr_q <= CH_W'(N_CH - 1);
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            ev_ch_q  <= ev_ch_d;
            rr_ptr_q <= rr_ptr_d;
            if ((|drop_evt) && (drop_q != '1)) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    assign req      = req_q;
    assign ev_ch    = ev_ch_q;
    assign busy     = (state_q != StIdle);
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_taxel_logic_aer_ctrl.sv
// Directed bench for taxel_logic_aer_ctrl; a second instance with DROP_W=2 covers saturation.
module tb_taxel_logic_aer_ctrl;

    logic       clk;
    logic       rstn;
    logic       spkgate_x;
    logic       spkgate_y;
    logic       vmode;
    logic [3:0] spk_in;
    logic       spk_in_imode;
    logic [3:0] refr_cycles;
    logic       ack;
    logic       req;
    logic [1:0] ev_ch;
    logic [3:0] pending;
    logic       busy;
    logic [7:0] drop_cnt;
    logic       req2;
    logic [1:0] ev_ch2;
    logic [3:0] pending2;
    logic       busy2;
    logic [1:0] drop_cnt2;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    taxel_logic_aer_ctrl #(
        .N_CH       (4),
        .SYNC_STAGES(2),
        .REFR_W     (4),
        .DROP_W     (8)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .spkgate_x   (spkgate_x),
        .spkgate_y   (spkgate_y),
        .vmode       (vmode),
        .spk_in      (spk_in),
        .spk_in_imode(spk_in_imode),
        .refr_cycles (refr_cycles),
        .req         (req),
        .ack         (ack),
        .ev_ch       (ev_ch),
        .pending     (pending),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    taxel_logic_aer_ctrl #(
        .N_CH       (4),
        .SYNC_STAGES(2),
        .REFR_W     (4),
        .DROP_W     (2)
    ) dut_sat (
        .clk         (clk),
        .rstn        (rstn),
        .spkgate_x   (spkgate_x),
        .spkgate_y   (spkgate_y),
        .vmode       (vmode),
        .spk_in      (spk_in),
        .spk_in_imode(spk_in_imode),
        .refr_cycles (refr_cycles),
        .req         (req2),
        .ack         (ack),
        .ev_ch       (ev_ch2),
        .pending     (pending2),
        .busy        (busy2),
        .drop_cnt    (drop_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        spk_in       = '0;
        spk_in_imode = 1'b0;
        ack          = 1'b0;
        spkgate_x    = 1'b0;
        spkgate_y    = 1'b0;
        vmode        = 1'b1;
        refr_cycles  = '0;
        rstn         = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic spike(input logic [3:0] mask);
        spk_in = mask;
        repeat (2) @(negedge clk);
        spk_in = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (req !== 1'b1) check_eq("req_timeout", 32'(req), 32'd1);
    endtask

    task automatic handshake(input logic [1:0] exp_ch, input string tag);
        wait_req();
        check_eq({tag, "_ev_ch"}, 32'(ev_ch), 32'(exp_ch));
        ack = 1'b1;
        @(negedge clk);
        check_eq({tag, "_req_low"}, 32'(req), 32'd0);
        check_eq({tag, "_pend_clr"}, 32'(pending[exp_ch]), 32'd0);
        ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        spk_in = '0; spk_in_imode = 1'b0; ack = 1'b0; spkgate_x = 1'b0; spkgate_y = 1'b0;
        vmode = 1'b1; refr_cycles = '0; rstn = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_req", 32'(req), 32'd0);
        check_eq("rst_ev_ch", 32'(ev_ch), 32'd0);
        check_eq("rst_pending", 32'(pending), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_drop", 32'(drop_cnt), 32'd0);

        // 1: single ch2 spike, req at edge 4
        do_reset();
        spk_in = 4'b0100;
        repeat (2) @(negedge clk);
        spk_in = '0;
        @(negedge clk);
        check_eq("t1_pend_e3", 32'(pending), 32'h4);
        check_eq("t1_req_e3", 32'(req), 32'd0);
        @(negedge clk);
        check_eq("t1_req_e4", 32'(req), 32'd1);
        check_eq("t1_busy_e4", 32'(busy), 32'd1);
        handshake(2'd2, "t1");
        repeat (8) @(negedge clk);
        check_eq("t1_no_second_req", 32'(req), 32'd0);
        check_eq("t1_idle", 32'(busy), 32'd0);

        // 2: round robin
        do_reset();
        spike(4'b1011);
        handshake(2'd0, "t2a");
        handshake(2'd1, "t2b");
        handshake(2'd3, "t2c");
        spike(4'b1001);
        handshake(2'd0, "t2d");
        handshake(2'd3, "t2e");

        // 3: gating
        do_reset();
        spkgate_x = 1'b1;
        spkgate_y = 1'b1;
        spike(4'b0010);
        repeat (3) @(negedge clk);
        check_eq("t3_gated_pend", 32'(pending), 32'd0);
        check_eq("t3_gated_req", 32'(req), 32'd0);
        check_eq("t3_gated_drop", 32'(drop_cnt), 32'd0);
        spkgate_y = 1'b0;
        spike(4'b0010);
        handshake(2'd1, "t3");

        // 4: overrun with ack held low
        do_reset();
        repeat (3) spike(4'b0010);
        check_eq("t4_drop2", 32'(drop_cnt), 32'd2);
        check_eq("t4_sat_drop2", 32'(drop_cnt2), 32'd2);
        check_eq("t4_pend", 32'(pending), 32'h2);
        repeat (3) spike(4'b0010);
        check_eq("t4_drop5", 32'(drop_cnt), 32'd5);
        check_eq("t4_sat_drop3", 32'(drop_cnt2), 32'd3);
        handshake(2'd1, "t4");

        // 5: refractory; G is the edge where req rises
        do_reset();
        refr_cycles = 4'd5;
        spk_in = 4'b0001;
        repeat (2) @(negedge clk);
        spk_in = '0;
        wait_req();
        check_eq("t5_ev_ch", 32'(ev_ch), 32'd0);
        ack = 1'b1;
        @(negedge clk);
        check_eq("t5_req_low", 32'(req), 32'd0);
        ack = 1'b0;
        @(negedge clk);
        spk_in = 4'b0001;
        repeat (2) @(negedge clk);
        spk_in = '0;
        repeat (2) @(negedge clk);
        check_eq("t5_refr_ignored", 32'(pending), 32'd0);
        check_eq("t5_refr_no_drop", 32'(drop_cnt), 32'd0);
        spk_in = 4'b0001;
        repeat (2) @(negedge clk);
        spk_in = '0;
        @(negedge clk);
        check_eq("t5_refr_accept", 32'(pending), 32'd1);
        handshake(2'd0, "t5");

        // 6: current mode, then async reset during REQ
        do_reset();
        vmode = 1'b0;
        spike(4'b0101);
        repeat (4) @(negedge clk);
        check_eq("t6_vmode0_pend", 32'(pending), 32'd0);
        check_eq("t6_vmode0_req", 32'(req), 32'd0);
        spk_in_imode = 1'b1;
        repeat (2) @(negedge clk);
        spk_in_imode = 1'b0;
        wait_req();
        check_eq("t6_imode_ev_ch", 32'(ev_ch), 32'd0);
        check_eq("t6_imode_pend", 32'(pending), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check_eq("t6_rst_req", 32'(req), 32'd0);
        check_eq("t6_rst_pend", 32'(pending), 32'd0);
        check_eq("t6_rst_busy", 32'(busy), 32'd0);
        check_eq("t6_rst_ev_ch", 32'(ev_ch), 32'd0);
        check_eq("t6_rst_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
